regfile_wb_sched: RTL
=====================

Name: regfile_wb_sched

Overview:
Write-back scheduler and scoreboard for the 32x32 register file (r0 hard-wired zero, single write port, two combinational read ports).
- Shares the single write port between two write-back requesters: req0 = ALU/EX path, req1 = load/multi-cycle unit. Uses round-robin arbitration.
- Tracks destination registers with an outstanding write, so issue logic can stall on RAW and WAW hazards.
- Drives the register file's WE/WriteReg/WriteData directly; the register file commits on the same CLK edge.

Parameters:
- NREQ_W, 6, width of outstanding-write counter (holds 0..31).

Ports:
- CLK  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- alloc_valid  in  1  issue stage announces an instruction with destination alloc_reg.
- alloc_reg  in  5  destination register of issuing instruction.
- alloc_ready  out  1  allocation accepted this cycle.
- req0_valid  in  1  requester 0 has a write-back.
- req0_reg  in  5  requester 0 destination.
- req0_data  in  32  requester 0 data.
- req0_ready  out  1  requester 0 granted this cycle.
- req1_valid, req1_reg, req1_data, req1_ready: same as req0, for requester 1.
- WE  out  1  register-file write enable.
- WriteReg  out  5  register-file write address.
- WriteData  out  32  register-file write data.
- chk_reg1  in  5  source register 1 of the instruction in decode.
- chk_reg2  in  5  source register 2 of the instruction in decode.
- stall  out  1  a source register has a pending write.
- pend_cnt  out  NREQ_W  number of pending registers.

Behaviour:
- **State:**
  - pending[31:1], one bit per register.
  - rr_last, 1 bit: last requester granted.
  - pend_cnt register.
- **Reset (clrn=0, asynchronous):**
  - pending=0, rr_last=1 (so req0 wins the first conflict), pend_cnt=0.
  - While clrn=0, force alloc_ready, req0_ready, req1_ready and WE to 0.
- **Arbitration (combinational, single cycle):**
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester other than rr_last.
  - rr_last updates to the granted index on the rising edge; unchanged when nothing is granted.
  - Handshake completes when valid && ready. A requester must hold reg/data stable while valid && !ready.
- **Write port:**
  - WriteReg/WriteData = granted requester's reg/data; both are 0 when nothing is granted.
  - WE = grant && WriteReg!=0.
  - A write to r0 is granted and consumed, but WE stays 0.
  - Latency: data is visible on the register-file read ports the cycle after grant.
- **Commit:**
  - A grant with reg!=0 clears pending[reg] at the rising edge.
  - A commit to a non-pending register is legal; pending stays 0.
- **Allocation:**
  - alloc_ready = alloc_valid && (alloc_reg==0 || !pending[alloc_reg]). Blocks a WAW against an outstanding write.
  - alloc_ready with alloc_reg!=0 sets pending[alloc_reg] at the edge. alloc_reg==0 never sets anything.
  - Allocation and commit to the same register in the same cycle can only occur when the register is not pending. Set wins: pending ends at 1.
- **Stall (combinational):**
  - stall = (chk_reg1!=0 && pending[chk_reg1]) || (chk_reg2!=0 && pending[chk_reg2]).
  - A commit in the current cycle does not lower stall until the next cycle. No bypass.
- **pend_cnt:**
  - +1 on a set, -1 on a clear of a set bit.
  - Both in one cycle on different registers: net 0.
  - Equals popcount(pending) at all times; never wraps (max 31).
- **Reset mid-operation:** all pending bits and any in-flight grant are discarded; no WE pulse during or on release of reset.

Test Plan:
- **Reset/idle:** clrn low then high, no stimulus → pend_cnt=0, stall=0, WE=0, all readies 0 while clrn=0.
- **Alloc/commit:**
  - alloc r5 → pending[5]=1, pend_cnt=1.
  - chk_reg1=5 → stall=1.
  - req0 writes r5 = 0xDEADBEEF → WE=1, WriteReg=5 that cycle; next cycle stall=0, pend_cnt=0, register-file r5 reads 0xDEADBEEF.
- **Round-robin:** req0 and req1 both held valid (r3 = 0x11, r4 = 0x22) from reset → req0 granted cycle 1, req1 cycle 2. Repeat with continuously valid streams → grants strictly alternate.
- **WAW block:** alloc r7, then alloc r7 again → second alloc_ready=0 until r7 commits. Same-cycle commit+alloc of unpended r9 → pending[9]=1.
- **r0 handling:** alloc r0 → alloc_ready=1, pend_cnt stays 0. req1 writes r0 = 0xFFFFFFFF → req1_ready=1, WE=0. chk_reg1=0 → stall=0.
- **Reset mid-op:** pend_cnt=3 with both requesters valid; pulse clrn low mid-cycle → WE drops immediately, pend_cnt=0, stall=0; after release, req0 wins first.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : regfile_wb_sched_if                                            |
// | Purpose   : Bundles the issue-side allocation handshake, the two           |
// |             write-back requester handshakes, the register-file write port  |
// |             and the hazard-check signals of regfile_wb_sched.              |
// | Modports  : slave  - the scheduler (consumes requests, drives write port)  |
// |             master - the surrounding pipeline / testbench                  |
// | Signals   : alloc_valid/alloc_reg/alloc_ready   allocation handshake       |
// |             reqN_valid/reqN_reg/reqN_data/reqN_ready  write-back requesters|
// |             WE/WriteReg/WriteData               register-file write port   |
// |             chk_reg1/chk_reg2/stall             RAW hazard check           |
// |             pend_cnt                            number of pending regs     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface regfile_wb_sched_if #(
  parameter int NREQ_W = 6
);
  // Allocation from the issue stage
  logic              alloc_valid;
  logic [4:0]        alloc_reg;
  logic              alloc_ready;

  // Requester 0: ALU / EX path
  logic              req0_valid;
  logic [4:0]        req0_reg;
  logic [31:0]       req0_data;
  logic              req0_ready;

  // Requester 1: load / multi-cycle unit
  logic              req1_valid;
  logic [4:0]        req1_reg;
  logic [31:0]       req1_data;
  logic              req1_ready;

  // Register-file write port
  logic              WE;
  logic [4:0]        WriteReg;
  logic [31:0]       WriteData;

  // Hazard check for the instruction in decode
  logic [4:0]        chk_reg1;
  logic [4:0]        chk_reg2;
  logic              stall;
  logic [NREQ_W-1:0] pend_cnt;

  modport slave (
    input  alloc_valid, alloc_reg,
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    input  chk_reg1, chk_reg2,
    output alloc_ready, req0_ready, req1_ready,
    output WE, WriteReg, WriteData,
    output stall, pend_cnt
  );

  modport master (
    output alloc_valid, alloc_reg,
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    output chk_reg1, chk_reg2,
    input  alloc_ready, req0_ready, req1_ready,
    input  WE, WriteReg, WriteData,
    input  stall, pend_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : regfile_wb_sched                                               |
// | Purpose   : Write-back scheduler and scoreboard for a 32x32 register file  |
// |             (r0 hard-wired zero, one write port). Shares the write port    |
// |             between two requesters with round-robin arbitration, and       |
// |             tracks registers with an outstanding write so that issue can   |
// |             stall on RAW hazards and allocation blocks WAW hazards.        |
// | Ports     : CLK   - clock, rising edge                                     |
// |             clrn  - asynchronous active-low reset                          |
// |             bus   - regfile_wb_sched_if.slave (handshakes, write port,     |
// |                     hazard check, pending count)                           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module regfile_wb_sched #(
  parameter int NREQ_W = 6
) (
  input wire logic           CLK,
  input wire logic           clrn,
  regfile_wb_sched_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Bit 0 exists only so the vector can be indexed directly by a 5-bit
  // register number; it is held at zero permanently.
  logic [31:0]       pending_q;
  logic [31:0]       pending_d;
  logic              rr_last_q;   // index of the requester granted last
  logic              rr_last_d;
  logic [NREQ_W-1:0] pend_cnt_q;
  logic [NREQ_W-1:0] pend_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic        gnt0;
  logic        gnt1;
  logic        gnt_any;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        we;
  logic        alloc_ok;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        cnt_inc;
  logic        cnt_dec;
  logic        stall;

  // --------------------------------------------------------------------------
  // Arbitration and write port
  // --------------------------------------------------------------------------
  // The handshake outputs are qualified by clrn directly so that an
  // asynchronous reset removes any in-flight grant (and the WE pulse) at once,
  // not just at the next clock edge.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    wr_reg  = 5'd0;
    wr_data = 32'd0;

    if (clrn) begin
      if (bus.req0_valid && bus.req1_valid) begin
        // Conflict: the requester not granted last time wins.
        gnt0 = rr_last_q;
        gnt1 = ~rr_last_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end

    if (gnt0) begin
      wr_reg  = bus.req0_reg;
      wr_data = bus.req0_data;
    end else if (gnt1) begin
      wr_reg  = bus.req1_reg;
      wr_data = bus.req1_data;
    end

    gnt_any = gnt0 | gnt1;
    // A write to r0 is consumed by the handshake but never reaches the array.
    we      = gnt_any && (wr_reg != 5'd0);
  end

  // --------------------------------------------------------------------------
  // Allocation, commit and scoreboard update
  // --------------------------------------------------------------------------
  always_comb begin
    alloc_ok = 1'b0;
    set_vec  = 32'd0;
    clr_vec  = 32'd0;

    if (clrn && bus.alloc_valid) begin
      alloc_ok = (bus.alloc_reg == 5'd0) || !pending_q[bus.alloc_reg];
    end

    if (alloc_ok && (bus.alloc_reg != 5'd0)) begin
      set_vec = 32'd1 << bus.alloc_reg;
    end

    if (we) begin
      clr_vec = 32'd1 << wr_reg;
    end

    // Clear first, then set: a same-cycle allocate and commit of one register
    // (only possible while it is not pending) leaves it pending.
    pending_d = ((pending_q & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;

    // A set always targets a non-pending register (alloc_ok guarantees it),
    // and a clear only counts when it actually removes a set bit. An allocate
    // can never target the register being cleared while it is pending, so the
    // two adjustments never refer to the same bit.
    cnt_inc    = |set_vec;
    cnt_dec    = |(clr_vec & pending_q);
    pend_cnt_d = pend_cnt_q + NREQ_W'(cnt_inc) - NREQ_W'(cnt_dec);

    rr_last_d = rr_last_q;
    if (gnt0) begin
      rr_last_d = 1'b0;
    end else if (gnt1) begin
      rr_last_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Hazard check: reads the registered scoreboard only, so a commit in the
  // current cycle lowers stall from the next cycle onwards.
  // --------------------------------------------------------------------------
  always_comb begin
    stall = ((bus.chk_reg1 != 5'd0) && pending_q[bus.chk_reg1]) ||
            ((bus.chk_reg2 != 5'd0) && pending_q[bus.chk_reg2]);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // rr_last resets to 1 so that requester 0 wins the first conflict.
  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      pending_q  <= 32'd0;
      rr_last_q  <= 1'b1;
      pend_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      rr_last_q  <= rr_last_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.alloc_ready = alloc_ok;
  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.WE          = we;
  assign bus.WriteReg    = wr_reg;
  assign bus.WriteData   = wr_data;
  assign bus.stall       = stall;
  assign bus.pend_cnt    = pend_cnt_q;

endmodule
`default_nettype wire
